// File: rtl/bit_serial_adder.sv
// bit_serial_adder: bit-serial ripple adder using one full-adder cell and a
// carry flip-flop. Operands are captured on an accepted start, one bit is
// added per clock LSB-first, and done pulses for one cycle once sum/cout are
// final.
//
// Optional feature: define SERIAL_ADDER_OVF_EN to add the ovf output
// (two's-complement overflow of the WIDTH-bit signed add). Without the macro
// the port and its logic are absent.
module bit_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [WIDTH-1:0] sa_reg, sb_reg, sum_reg;
  logic             c_reg, cout_reg;
  logic [CW-1:0]    cnt_reg;

  logic             load;
  logic             last_bit;
  logic             s_bit;
  logic             c_next;

  // Full-adder cell on the current LSBs plus the stored carry.
  assign s_bit    = sa_reg[0] ^ sb_reg[0] ^ c_reg;
  assign c_next   = (sa_reg[0] & sb_reg[0]) | (sa_reg[0] & c_reg) | (sb_reg[0] & c_reg);
  assign load     = (state_reg == IDLE) && start;
  assign last_bit = (cnt_reg == CW'(WIDTH - 1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: start only matters in IDLE; DONE lasts exactly one cycle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start)    state_next = ADD;
      ADD:     if (last_bit) state_next = DONE;
      DONE:                  state_next = IDLE;
      default:               state_next = IDLE;
    endcase
  end

  // Datapath: capture on accepted start, then shift one bit per clock in ADD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa_reg   <= '0;
      sb_reg   <= '0;
      sum_reg  <= '0;
      c_reg    <= 1'b0;
      cout_reg <= 1'b0;
      cnt_reg  <= '0;
    end else if (load) begin
      sa_reg   <= a;
      sb_reg   <= b;
      c_reg    <= cin;
      sum_reg  <= '0;
      cout_reg <= 1'b0;
      cnt_reg  <= '0;
    end else if (state_reg == ADD) begin
      sa_reg  <= sa_reg >> 1;
      sb_reg  <= sb_reg >> 1;
      sum_reg <= {s_bit, sum_reg[WIDTH-1:1]};
      c_reg   <= c_next;
      cnt_reg <= cnt_reg + CW'(1);
      if (last_bit) begin
        cout_reg <= c_next;
      end
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  logic ovf_reg;

  // Overflow: carry into the sign bit differs from carry out of it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_reg <= 1'b0;
    end else if (load) begin
      ovf_reg <= 1'b0;
    end else if (state_reg == ADD && last_bit) begin
      ovf_reg <= c_reg ^ c_next;
    end
  end

  assign ovf = ovf_reg;
`endif

  assign busy = (state_reg == ADD);
  assign done = (state_reg == DONE);
  assign sum  = sum_reg;
  assign cout = cout_reg;

endmodule

// File: tb/tb_bit_serial_adder.sv
// tb_bit_serial_adder: scoreboard bench. Stimulus pushes the expected
// {ovf, cout, sum} per issued add; a monitor pops and compares on every done.
module tb_bit_serial_adder;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
  logic             busy, done, cout;
  logic [WIDTH-1:0] sum;
  logic             ovf_obs;

  bit_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf_obs)
`endif
  );

`ifndef SERIAL_ADDER_OVF_EN
  assign ovf_obs = 1'b0;
`endif

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc_q[$];
  logic [WIDTH+1:0] exp_q[$];   // {ovf, cout, sum}

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("[TB] ok   %s: %0h", name, act);
    end
  endtask

  // Monitor: every done pulse consumes one scoreboard entry.
  always @(negedge clk) begin
    if (!rst && done) begin
      logic [WIDTH+1:0] e;
      done_cnt++;
      done_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got sum=%0h cout=%0b expected no done", sum, cout);
      end else begin
        e = exp_q.pop_front();
        check("sum", 64'(sum), 64'(e[WIDTH-1:0]));
        check("cout", 64'(cout), 64'(e[WIDTH]));
`ifdef SERIAL_ADDER_OVF_EN
        check("ovf", 64'(ovf_obs), 64'(e[WIDTH+1]));
`endif
      end
    end
  end

  // Present operands for one edge; returns with start low at the negedge after acceptance.
  task automatic issue(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                       input logic tc, input logic push, input logic [WIDTH+1:0] e);
    @(negedge clk);
    a = ta; b = tb; cin = tc; start = 1'b1;
    if (push) exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done_count(input int target, input string name);
    int n = 0;
    while (done_cnt < target && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt < target) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got %0d done pulses expected %0d", name, done_cnt, target);
    end
  endtask

  initial begin
    int start_cyc, busy_n, base, d0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_cout", 64'(cout), 64'd0);
    check("rst_ovf", 64'(ovf_obs), 64'd0);
    rst = 1'b0;

    // Reset mid-operation: asynchronous clear, aborted op never completes.
    issue(8'hAA, 8'h55, 1'b0, 1'b0, '0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_sum", 64'(sum), 64'd0);
    check("midrst_cout", 64'(cout), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // 3C + 5A: also latency and busy length.
    base = done_cnt;
    issue(8'h3C, 8'h5A, 1'b0, 1'b1, {1'b1, 1'b0, 8'h96});
    start_cyc = cyc;   // edge count at the accepting edge
    busy_n = 0;
    for (int i = 0; i < 30 && !done; i++) begin
      if (busy) busy_n++;
      @(negedge clk);
    end
    check("busy_cycles", 64'(busy_n), 64'd8);
    check("done_latency", 64'(cyc - start_cyc + 1), 64'd9);   // counting the start edge
    wait_done_count(base + 1, "add_3c5a");

    issue(8'hFF, 8'h01, 1'b0, 1'b1, {1'b0, 1'b1, 8'h00});
    wait_done_count(base + 2, "add_ff01");
    issue(8'hFF, 8'hFF, 1'b1, 1'b1, {1'b0, 1'b1, 8'hFF});
    wait_done_count(base + 3, "add_ffff1");

    // Start pulsed mid-ADD must be ignored: one done, original result.
    issue(8'h10, 8'h20, 1'b0, 1'b1, {1'b0, 1'b0, 8'h30});
    repeat (2) @(negedge clk);
    a = 8'hF0; b = 8'hF0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done_count(base + 4, "add_1020");
    repeat (15) @(negedge clk);
    check("single_done", 64'(done_cnt - base), 64'd4);

    // start held: back-to-back adds, done every WIDTH+2 cycles.
    d0 = done_cyc_q.size();
    repeat (3) exp_q.push_back({1'b1, 1'b0, 8'h80});
    @(negedge clk);
    a = 8'h7F; b = 8'h01; cin = 1'b0; start = 1'b1;
    wait_done_count(base + 7, "held_start");
    start = 1'b0;
    if (done_cyc_q.size() >= d0 + 3) begin
      check("spacing_1", 64'(done_cyc_q[d0+1] - done_cyc_q[d0]), 64'd10);
      check("spacing_2", 64'(done_cyc_q[d0+2] - done_cyc_q[d0+1]), 64'd10);
    end
    repeat (15) @(negedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
